// File: rtl/cic_pdm_decim_pkg.sv
// Shared constants, width helper and the round/saturate stage for the PDM CIC decimator.
package cic_pkg;

    localparam int ORDER_MAX      = 5;
    localparam int DECIM_LOG2_MAX = 8;
    localparam int SAT_W          = 64;

    typedef struct packed {
        logic                    sat;
        logic signed [SAT_W-1:0] value;
    } sat_result_t;

    function automatic int cic_acc_w(input int order, input int decim_log2);
        return order * decim_log2 + 2;
    endfunction

    // Round half up, arithmetic shift, then clip to a signed out_w-bit range.
    function automatic sat_result_t sat_round(input logic signed [SAT_W-1:0] value,
                                              input int shift, input int out_w);
        logic signed [SAT_W-1:0] rounded;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_result_t             r;
        rounded = value;
        if (shift > 0) begin
            rounded = (value + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (out_w - 1));
        r.sat   = 1'b0;
        r.value = rounded;
        if (rounded > hi) begin
            r.sat   = 1'b1;
            r.value = hi;
        end else if (rounded < lo) begin
            r.sat   = 1'b1;
            r.value = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/cic_pdm_decim_channel.sv
// One CIC channel: wrap-around integrator cascade plus comb chain evaluated on decimation ticks.
module cic_channel
    import cic_pkg::*;
#(
    parameter int ORDER = 3,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tick,
    input  logic             clear,
    input  logic             pdm_bit,
    output logic [ACC_W-1:0] comb_out
);

    logic [ACC_W-1:0] integ    [ORDER];
    logic [ACC_W-1:0] dly      [ORDER];
    logic [ACC_W-1:0] stage_in [ORDER];
    logic [ACC_W-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
                integ[k] <= '0;
                dly[k]   <= '0;
            end
        end else if (clear) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
                integ[k] <= '0;
                dly[k]   <= '0;
            end
        end else begin
            if (en) begin
                integ[0] <= integ[0] + (pdm_bit ? ACC_W'(1) : '1);
                for (int unsigned k = 1; k < ORDER; k++) begin
                    integ[k] <= integ[k] + integ[k-1];
                end
            end
            if (tick) begin
                for (int unsigned k = 0; k < ORDER; k++) begin
                    dly[k] <= stage_in[k];
                end
            end
        end
    end

    // Running difference keeps the chain free of array self-reference.
    always_comb begin
        acc = integ[ORDER-1];
        for (int unsigned k = 0; k < ORDER; k++) begin
            stage_in[k] = acc;
            acc         = acc - dly[k];
        end
        comb_out = acc;
    end

endmodule

// File: rtl/cic_pdm_decim.sv
// Multi-channel PDM-to-PCM CIC decimator with warm-up suppression, saturation and valid/ready output.
module cic_pdm_decim
    import cic_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int ORDER      = 3,
    parameter int DECIM_LOG2 = 6,
    parameter int OUT_W      = 16,
    parameter int OUT_SHIFT  = cic_acc_w(ORDER, DECIM_LOG2) - OUT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       pdm_in,
    output logic [CHANNELS*OUT_W-1:0] pcm_data,
    output logic                      pcm_valid,
    input  logic                      pcm_ready,
    output logic                      pcm_sat,
    output logic                      overrun,
    input  logic                      overrun_clr
);

    localparam int ACC_W  = cic_acc_w(ORDER, DECIM_LOG2);
    localparam int WARM_W = $clog2(ORDER_MAX + 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(ORDER);

    if (ORDER < 1 || ORDER > ORDER_MAX) begin : g_bad_order
        $error("cic_pdm_decim: ORDER must be in 1..%0d", ORDER_MAX);
    end
    if (DECIM_LOG2 < 2 || DECIM_LOG2 > DECIM_LOG2_MAX) begin : g_bad_decim
        $error("cic_pdm_decim: DECIM_LOG2 must be in 2..%0d", DECIM_LOG2_MAX);
    end
    if (OUT_SHIFT < 0 || OUT_SHIFT >= ACC_W) begin : g_bad_shift
        $error("cic_pdm_decim: OUT_SHIFT must be in 0..ACC_W-1");
    end

    logic [DECIM_LOG2-1:0]     dec_cnt;
    logic [WARM_W-1:0]         warm_cnt;
    logic                      tick;
    logic                      deliver;
    logic [ACC_W-1:0]          comb_out [CHANNELS];
    logic [CHANNELS*OUT_W-1:0] next_data;
    logic                      next_sat;
    logic [OUT_W:0]            scaled;

    assign tick    = en && (dec_cnt == '1);
    assign deliver = tick && !clear && (warm_cnt == WARM_DONE);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        cic_channel #(
            .ORDER (ORDER),
            .ACC_W (ACC_W)
        ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .tick     (tick),
            .clear    (clear),
            .pdm_bit  (pdm_in[ch]),
            .comb_out (comb_out[ch])
        );
    end

    function automatic logic [OUT_W:0] scale_sample(input logic [ACC_W-1:0] c);
        sat_result_t r;
        r = sat_round(SAT_W'(signed'(c)), OUT_SHIFT, OUT_W);
        return {r.sat, r.value[OUT_W-1:0]};
    endfunction

    always_comb begin
        next_data = '0;
        next_sat  = 1'b0;
        scaled    = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            scaled                       = scale_sample(comb_out[ch]);
            next_data[ch*OUT_W +: OUT_W] = scaled[OUT_W-1:0];
            next_sat                     = next_sat | scaled[OUT_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt   <= '0;
            warm_cnt  <= '0;
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            pcm_sat   <= 1'b0;
        end else if (clear) begin
            dec_cnt   <= '0;
            warm_cnt  <= '0;
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            pcm_sat   <= 1'b0;
        end else begin
            if (en) begin
                dec_cnt <= dec_cnt + DECIM_LOG2'(1);
            end
            if (tick && warm_cnt != WARM_DONE) begin
                warm_cnt <= warm_cnt + WARM_W'(1);
            end
            if (deliver) begin
                pcm_data  <= next_data;
                pcm_sat   <= next_sat;
                pcm_valid <= 1'b1;
            end else if (pcm_valid && pcm_ready) begin
                pcm_valid <= 1'b0;
            end
        end
    end

    // deliver is already masked by clear, so a clear never raises overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (deliver && pcm_valid && !pcm_ready) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic_pdm_decim.sv
// Scoreboard bench: FIR-equivalent CIC reference model feeds expected PCM queues; a monitor checks them.
module tb_cic_pdm_decim;

    localparam int N    = 3;
    localparam int R    = 64;
    localparam int HLEN = N * (R - 1) + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  pdm_in = 2'b00;
    logic        pcm_ready = 1'b0;
    logic        overrun_clr = 1'b0;
    logic [31:0] pcm_data, pcm_data_s3;
    logic        pcm_valid, pcm_valid_s3;
    logic        pcm_sat, pcm_sat_s3;
    logic        overrun, overrun_s3;

    always #5 clk = ~clk;

    cic_pdm_decim #(.CHANNELS(2), .ORDER(3), .DECIM_LOG2(6), .OUT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .pdm_in(pdm_in),
        .pcm_data(pcm_data), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
        .pcm_sat(pcm_sat), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    cic_pdm_decim #(.CHANNELS(2), .ORDER(3), .DECIM_LOG2(6), .OUT_W(16), .OUT_SHIFT(3)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .pdm_in(pdm_in),
        .pcm_data(pcm_data_s3), .pcm_valid(pcm_valid_s3), .pcm_ready(pcm_ready),
        .pcm_sat(pcm_sat_s3), .overrun(overrun_s3), .overrun_clr(overrun_clr)
    );

    typedef struct {
        logic [31:0] data;
        logic        sat;
    } exp_t;

    longint h [HLEN];
    int     xs0[$], xs1[$];
    exp_t   q4[$], q3[$];
    int     mcnt = 0, mwarm = 0;
    bit     mvalid = 0, movr = 0, mvalid_cur = 0, movr_cur = 0;
    int     vectors = 0, miscompares = 0;
    bit     done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // CIC impulse response = R-tap boxcar convolved with itself N times.
    function automatic void build_h();
        longint tmp [HLEN];
        int len = 1;
        for (int i = 0; i < HLEN; i++) h[i] = (i == 0) ? 1 : 0;
        for (int s = 0; s < N; s++) begin
            for (int i = 0; i < HLEN; i++) begin
                tmp[i] = 0;
                for (int t = 0; t < R; t++) if (i - t >= 0) tmp[i] += h[i-t];
            end
            len += R - 1;
            for (int i = 0; i < HLEN; i++) h[i] = (i < len) ? tmp[i] : 0;
        end
    endfunction

    // Output at a tick sees inputs up to N enabled samples before the tick sample.
    function automatic longint cic_ref(input int ch);
        longint s = 0;
        int     last, idx;
        last = (ch == 0 ? xs0.size() : xs1.size()) - 1;
        for (int j = 0; j < HLEN; j++) begin
            idx = last - N - j;
            if (idx < 0) break;
            s += h[j] * longint'(ch == 0 ? xs0[idx] : xs1[idx]);
        end
        return s;
    endfunction

    function automatic exp_t make_exp(input longint y0, input longint y1, input int shift);
        exp_t   e;
        longint ys [2];
        longint v;
        ys[0]  = y0;
        ys[1]  = y1;
        e.data = '0;
        e.sat  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            v = longint'($floor(real'(ys[c]) / (2.0 ** shift) + 0.5));
            if (v > 32767) begin
                v = 32767;
                e.sat = 1'b1;
            end else if (v < -32768) begin
                v = -32768;
                e.sat = 1'b1;
            end
            e.data[c*16 +: 16] = v[15:0];
        end
        return e;
    endfunction

    function automatic void model_reset();
        xs0.delete(); xs1.delete(); q4.delete(); q3.delete();
        mcnt = 0; mwarm = 0; mvalid = 0; movr = 0; mvalid_cur = 0; movr_cur = 0;
    endfunction

    function automatic void model_edge(input bit e, input bit clr, input bit [1:0] pdm,
                                       input bit rdy, input bit oclr);
        bit     set_ovr = 0, tk = 0, dlv = 0;
        longint y0, y1;
        if (clr) begin
            xs0.delete(); xs1.delete();
            mcnt = 0; mwarm = 0;
            if (mvalid && !rdy) begin
                void'(q4.pop_back()); void'(q3.pop_back());
            end
            mvalid = 0;
        end else begin
            if (e) begin
                xs0.push_back(pdm[0] ? 1 : -1);
                xs1.push_back(pdm[1] ? 1 : -1);
                tk   = (mcnt == R - 1);
                mcnt = (mcnt + 1) % R;
            end
            if (tk) begin
                if (mwarm < N) mwarm++;
                else dlv = 1;
            end
            if (dlv) begin
                y0 = cic_ref(0);
                y1 = cic_ref(1);
                if (mvalid && !rdy) begin
                    void'(q4.pop_back()); void'(q3.pop_back());
                    set_ovr = 1;
                end
                q4.push_back(make_exp(y0, y1, 4));
                q3.push_back(make_exp(y0, y1, 3));
                mvalid = 1;
            end else if (mvalid && rdy) begin
                mvalid = 0;
            end
        end
        if (set_ovr) movr = 1;
        else if (oclr) movr = 0;
    endfunction

    task automatic step(input bit e, input bit clr, input bit [1:0] pdm, input bit rdy, input bit oclr);
        @(negedge clk);
        mvalid_cur  = mvalid;
        movr_cur    = movr;
        en          = e;
        clear       = clr;
        pdm_in      = pdm;
        pcm_ready   = rdy;
        overrun_clr = oclr;
        model_edge(e, clr, pdm, rdy, oclr);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data"}, pcm_data, 0);
        check({tag, "_valid"}, pcm_valid, 0);
        check({tag, "_sat"}, pcm_sat, 0);
        check({tag, "_data_s3"}, pcm_data_s3, 0);
        check({tag, "_valid_s3"}, pcm_valid_s3, 0);
    endtask

    task automatic fill_until_valid(input string tag);
        int k = 0;
        while (!mvalid && k < 400) begin
            step(1, 0, 2'($urandom_range(0, 3)), 0, 0);
            k++;
        end
        check({tag, "_wait_valid"}, mvalid, 1);
    endtask

    // Monitor: every cycle compare handshake state, and pop/compare on each DUT transfer.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            #2;
            if (rst_n && !done) begin
                check("valid", pcm_valid, mvalid_cur);
                check("valid_s3", pcm_valid_s3, mvalid_cur);
                check("overrun", overrun, movr_cur);
                check("overrun_s3", overrun_s3, movr_cur);
                if (pcm_valid && pcm_ready) begin
                    if (q4.size() == 0) begin
                        check("q4_nonempty", 0, 1);
                    end else begin
                        e = q4.pop_front();
                        check("data", pcm_data, e.data);
                        check("sat", pcm_sat, e.sat);
                    end
                end
                if (pcm_valid_s3 && pcm_ready) begin
                    if (q3.size() == 0) begin
                        check("q3_nonempty", 0, 1);
                    end else begin
                        e = q3.pop_front();
                        check("data_s3", pcm_data_s3, e.data);
                        check("sat_s3", pcm_sat_s3, e.sat);
                    end
                end
            end
        end
    end

    initial begin
        bit alt = 0;
        int dens;
        build_h();
        model_reset();
        repeat (3) @(negedge clk);
        #1 check_zero_outputs("reset");
        check("reset_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All ones, then ch0 zeros / ch1 alternating, then all zeros (clip on the shift-3 instance).
        repeat (600) step(1, 0, 2'b11, 1, 0);
        repeat (600) begin
            alt = ~alt;
            step(1, 0, {alt, 1'b0}, 1, 0);
        end
        repeat (600) step(1, 0, 2'b00, 1, 0);

        // 50% enable duty with all ones.
        repeat (900) begin
            alt = ~alt;
            step(alt, 0, 2'b11, 1, 0);
        end

        // Randomised traffic with biased PDM density, random enable, back-pressure and overrun clears.
        for (int blk = 0; blk < 6; blk++) begin
            dens = $urandom_range(5, 95);
            repeat (500) step($urandom_range(0, 3) != 0, 0,
                              {2'($urandom_range(0, 99) < dens), 1'($urandom_range(0, 99) < 100 - dens)},
                              $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end

        // Stall across two ticks, then clear the sticky flag, then ready only on tick edges.
        repeat (200) step(1, 0, 2'($urandom_range(0, 3)), 0, 0);
        step(1, 0, 2'b11, 1, 1);
        repeat (400) step(1, 0, 2'($urandom_range(0, 3)), mcnt == R - 1, 0);

        // Clear with a pending sample, then warm-up restarts.
        fill_until_valid("clear");
        step(1, 1, 2'b11, 0, 0);
        step(1, 0, 2'b11, 0, 0);
        #1 check("clear_data", pcm_data, 0);
        check("clear_data_s3", pcm_data_s3, 0);
        repeat (500) step(1, 0, 2'b11, 1, 0);

        // Asynchronous reset while a sample is pending.
        fill_until_valid("arst");
        #3;
        rst_n = 1'b0; en = 0; clear = 0; pcm_ready = 0; overrun_clr = 0;
        #1 check_zero_outputs("arst");
        check("arst_overrun", overrun, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (500) step(1, 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, 0);

        step(0, 0, 2'b00, 1, 0);
        done = 1;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
